// File: rtl/gf_tower_pkg.sv
// Tower-field GF(2^8) definitions shared by the shared-unit arbiter and the elimination engines.
// Field is GF(((2^2)^2)^2): w^2 = w + 1, x^2 = x + w, y^2 = y + 0x8; bits are {high coeff, low coeff}.
package gf_tower_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_INV = 1'b1;
  localparam int   GF_W   = 8;

  localparam logic [1:0] GF16_NU      = 2'b10;
  localparam logic [3:0] GF256_LAMBDA = 4'h8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic hh;
    hh = a[1] & b[1];
    return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
  endfunction

  // In GF(4) squaring is linear and also yields the inverse (a^3 = 1 for a != 0).
  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    hh = gf4_mul(a[3:2], b[3:2]);
    return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
            gf4_mul(hh, GF16_NU) ^ gf4_mul(a[1:0], b[1:0])};
  endfunction

  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [1:0] d, di;
    d  = gf4_mul(gf4_sq(a[3:2]), GF16_NU) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
    di = gf4_sq(d);
    return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
  endfunction

  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, GF256_LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  // Norm-based inverse; a zero input gives zero here, the caller maps it.
  function automatic logic [7:0] gf256_inv(input logic [7:0] a);
    logic [3:0] d, di;
    d  = gf16_mul(gf16_mul(a[7:4], a[7:4]), GF256_LAMBDA) ^
         gf16_mul(a[7:4], a[3:0]) ^ gf16_mul(a[3:0], a[3:0]);
    di = gf16_inv(d);
    return {gf16_mul(a[7:4], di), gf16_mul(a[7:4] ^ a[3:0], di)};
  endfunction

endpackage

// File: rtl/gf256_tower_units.sv
// Combinational tower-field multiplier and inverter forming the single shared datapath.
// The inverter follows the table convention where the inverse of 0x00 is 0x01.
module mul256_Tower
  import gf_tower_pkg::*;
(
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  output logic [GF_W-1:0] p
);

  assign p = gf256_mul(a, b);

endmodule

module inv256_Tower
  import gf_tower_pkg::*;
(
  input  logic [GF_W-1:0] a,
  output logic [GF_W-1:0] q
);

  assign q = (a == 8'h00) ? 8'h01 : gf256_inv(a);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr, ptr+1, ... mod N and grants the first requester.
// Reusable wherever a rotating-priority one-hot grant with its index is needed.
module rr_arbiter
  import gf_tower_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [clog2(N)-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic [clog2(N)-1:0] gnt_idx
);

  localparam int IW = clog2(N);
  localparam int SW = IW + 1;

  logic [SW-1:0] pos;
  logic          found;

  // pos is ptr+i wrapped into 0..N-1 without a modulo operator, so non power-of-two N works.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + SW'(i);
      if (pos >= SW'(N)) pos = pos - SW'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found              = 1'b1;
        gnt[pos[IW-1:0]]   = 1'b1;
        gnt_idx            = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/gf256_shared_unit_arbiter.sv
// Shares one tower-field MUL/INV datapath among N_REQ requesters with round-robin grant
// and a stallable PIPE-deep, ID-tagged result pipeline.
module gf256_shared_unit_arbiter
  import gf_tower_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PIPE  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_op,
  input  logic [GF_W*N_REQ-1:0]    req_a,
  input  logic [GF_W*N_REQ-1:0]    req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [clog2(N_REQ)-1:0]  rsp_id,
  output logic [GF_W-1:0]          rsp_data,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam int IDW = clog2(N_REQ);

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   ptr;
  logic             adv;
  logic             accept;
  logic             op_sel;
  logic [GF_W-1:0]  op_a, op_b, mul_res, inv_res, result;

  logic [PIPE-1:0]  stage_v;
  logic [IDW-1:0]   stage_id [PIPE];
  logic [GF_W-1:0]  stage_d  [PIPE];

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A held result at the tail freezes every stage; ready is also masked while reset is asserted.
  assign adv       = ~stage_v[PIPE-1] | rsp_ready;
  assign req_ready = (adv && !rst) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);

  assign op_sel = req_op[gnt_idx];
  assign op_a   = req_a[{gnt_idx, 3'b000} +: GF_W];
  assign op_b   = req_b[{gnt_idx, 3'b000} +: GF_W];

  mul256_Tower u_mul (
    .a (op_a),
    .b (op_b),
    .p (mul_res)
  );

  inv256_Tower u_inv (
    .a (op_a),
    .q (inv_res)
  );

  assign result = (op_sel == OP_INV) ? inv_res : mul_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_v <= '0;
      ptr     <= '0;
      for (int i = 0; i < PIPE; i++) begin
        stage_id[i] <= '0;
        stage_d[i]  <= '0;
      end
    end else begin
      if (accept) begin
        ptr <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (adv) begin
        stage_v[0] <= accept;
        if (accept) begin
          stage_id[0] <= gnt_idx;
          stage_d[0]  <= result;
        end
        for (int i = 1; i < PIPE; i++) begin
          stage_v[i]  <= stage_v[i-1];
          stage_id[i] <= stage_id[i-1];
          stage_d[i]  <= stage_d[i-1];
        end
      end
    end
  end

  assign rsp_valid = stage_v[PIPE-1];
  assign rsp_id    = stage_id[PIPE-1];
  assign rsp_data  = stage_d[PIPE-1];
  assign busy      = |stage_v;

endmodule

// File: tb/tb_gf256_shared_unit_arbiter.sv
// Directed bench for the shared GF(2^8) unit arbiter: hand-computed field results,
// a round-robin grant model and an in-order scoreboard of expected {id, data}.
module tb_gf256_shared_unit_arbiter;
  import gf_tower_pkg::*;

  localparam int N_REQ = 4;
  localparam int PIPE  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid, req_op, req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;

  logic       lane_v [4];
  logic       lane_op [4];
  logic [7:0] lane_a [4];
  logic [7:0] lane_b [4];
  logic [7:0] lane_exp [4];
  logic       lane_care [4];

  logic [1:0] sb_id [$];
  logic [8:0] sb_data [$];

  int         checks = 0;
  int         errors = 0;
  int         exp_ptr = 0;
  int         rsp_count = 0;
  int         base;
  logic       accepted;
  logic [7:0] last_rsp;
  logic [7:0] inv_r, prod_r;

  assign req_valid = {lane_v[3], lane_v[2], lane_v[1], lane_v[0]};
  assign req_op    = {lane_op[3], lane_op[2], lane_op[1], lane_op[0]};
  assign req_a     = {lane_a[3], lane_a[2], lane_a[1], lane_a[0]};
  assign req_b     = {lane_b[3], lane_b[2], lane_b[1], lane_b[0]};

  always #5 clk = ~clk;

  gf256_shared_unit_arbiter #(.N_REQ(N_REQ), .PIPE(PIPE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input logic [1:0] ln, input logic v, input logic op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] e, input logic care);
    lane_v[ln]    = v;
    lane_op[ln]   = op;
    lane_a[ln]    = a;
    lane_b[ln]    = b;
    lane_exp[ln]  = e;
    lane_care[ln] = care;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) lane_v[2'(i)] = 1'b0;
  endtask

  // Lane set A: three inverses and one product with hand-derived results.
  task automatic load_set_a();
    set_lane(2'd0, 1'b1, OP_INV, 8'h04, 8'h00, 8'h0F, 1'b1);
    set_lane(2'd1, 1'b1, OP_INV, 8'h10, 8'h00, 8'hAA, 1'b1);
    set_lane(2'd2, 1'b1, OP_INV, 8'hFF, 8'h00, 8'h30, 1'b1);
    set_lane(2'd3, 1'b1, OP_MUL, 8'h02, 8'h03, 8'h01, 1'b1);
  endtask

  // Lane set B: y*y = y+lambda, x*x = x+nu, INV(0) convention, identity product.
  task automatic load_set_b();
    set_lane(2'd0, 1'b1, OP_MUL, 8'h10, 8'h10, 8'h18, 1'b1);
    set_lane(2'd1, 1'b1, OP_MUL, 8'h04, 8'h04, 8'h06, 1'b1);
    set_lane(2'd2, 1'b1, OP_INV, 8'h00, 8'h00, 8'h01, 1'b1);
    set_lane(2'd3, 1'b1, OP_MUL, 8'h01, 8'h5A, 8'h5A, 1'b1);
  endtask

  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[2'((p + i) % 4)]) return (p + i) % 4;
    end
    return -1;
  endfunction

  // One clock: check grant against the model, score any response handshake, log any accept.
  task automatic cycle();
    int         g;
    logic [3:0] exp_rdy;
    logic       adv_m;
    logic [1:0] id;
    logic [8:0] e;
    #1;
    adv_m   = !rsp_valid || rsp_ready;
    g       = model_grant(req_valid, exp_ptr);
    exp_rdy = (adv_m && g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("grant", req_ready, exp_rdy);
    if (rsp_valid && rsp_ready) begin
      rsp_count++;
      last_rsp = rsp_data;
      checks++;
      assert (sb_id.size() != 0) else begin
        errors++;
        $error("[TB] FAIL rsp_unexpected: observed id 0x%0h data 0x%0h expected no response", rsp_id, rsp_data);
      end
      if (sb_id.size() != 0) begin
        id = sb_id.pop_front();
        e  = sb_data.pop_front();
        check("rsp_id", rsp_id, id);
        if (e[8]) check("rsp_data", rsp_data, e[7:0]);
      end
    end
    if (adv_m && g >= 0) begin
      sb_id.push_back(2'(g));
      sb_data.push_back({lane_care[2'(g)], lane_exp[2'(g)]});
      exp_ptr  = (g + 1) % 4;
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb_id.size() != 0 && k < 20) begin
      cycle();
      k++;
    end
    check("drain_left", sb_id.size(), 0);
  endtask

  task automatic do_op(input logic [1:0] ln, input logic op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] e, input logic care,
                       output logic [7:0] r);
    set_lane(ln, 1'b1, op, a, b, e, care);
    accepted = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) cycle();
    check("accept_seen", accepted, 1'b1);
    lane_v[ln] = 1'b0;
    wait_drain();
    r = last_rsp;
  endtask

  task automatic do_reset();
    clear_lanes();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ptr = 0;
    sb_id.delete();
    sb_data.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rsp_ready = 1'b1;
    load_set_a();

    // Reset state, with all requests pending to show ready stays low.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 2'd0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    clear_lanes();
    rst = 1'b0;
    exp_ptr = 0;

    // 1: single MUL from requester 0, latency of PIPE cycles.
    set_lane(2'd0, 1'b1, OP_MUL, 8'h02, 8'h03, 8'h01, 1'b1);
    #1 check("t1_ready", req_ready, 4'b0001);
    cycle();
    lane_v[0] = 1'b0;
    for (int c = 1; c < PIPE; c++) begin
      #1;
      check("t1_latency_low", rsp_valid, 1'b0);
      check("t1_busy", busy, 1'b1);
      cycle();
    end
    #1;
    check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_rsp_id", rsp_id, 2'd0);
    check("t1_rsp_data", rsp_data, 8'h01);
    cycle();
    check("t1_idle", busy, 1'b0);

    // 2: directed inverses from requester 1, directed products, then MUL(a, INV(a)) = 1 sweep.
    do_op(2'd1, OP_INV, 8'h04, 8'h00, 8'h0F, 1'b1, inv_r);
    do_op(2'd1, OP_INV, 8'h10, 8'h00, 8'hAA, 1'b1, inv_r);
    do_op(2'd1, OP_INV, 8'h00, 8'h00, 8'h01, 1'b1, inv_r);
    do_op(2'd1, OP_INV, 8'hFF, 8'h00, 8'h30, 1'b1, inv_r);
    do_op(2'd1, OP_INV, 8'h01, 8'h00, 8'h01, 1'b1, inv_r);
    do_op(2'd0, OP_MUL, 8'h10, 8'h10, 8'h18, 1'b1, prod_r);
    do_op(2'd0, OP_MUL, 8'h04, 8'h04, 8'h06, 1'b1, prod_r);
    for (int a = 1; a < 256; a++) begin
      do_op(2'd1, OP_INV, 8'(a), 8'h00, 8'h00, 1'b0, inv_r);
      do_op(2'd2, OP_MUL, 8'(a), inv_r, 8'h01, 1'b1, prod_r);
    end

    // 3: all four requesting continuously from ptr=0.
    do_reset();
    load_set_a();
    base = rsp_count;
    for (int k = 0; k < 8; k++) begin
      #1 check("t3_grant_seq", req_ready, 4'b0001 << (k % 4));
      cycle();
    end
    clear_lanes();
    wait_drain();
    check("t3_rsp_count", rsp_count - base, 8);

    // 4: backpressure with a full pipe, then release.
    load_set_b();
    rsp_ready = 1'b0;
    base = rsp_count;
    for (int k = 0; k < PIPE; k++) cycle();
    for (int s = 0; s < 5; s++) begin
      #1;
      check("t4_req_ready", req_ready, 4'b0000);
      check("t4_rsp_valid", rsp_valid, 1'b1);
      check("t4_busy", busy, 1'b1);
      check("t4_rsp_id", rsp_id, 2'd0);
      check("t4_rsp_data", rsp_data, 8'h18);
      cycle();
    end
    clear_lanes();
    rsp_ready = 1'b1;
    wait_drain();
    check("t4_rsp_count", rsp_count - base, PIPE);
    cycle();
    cycle();

    // 5: only requesters 2 and 3, then a withdrawal that must leave ptr in place.
    do_reset();
    set_lane(2'd2, 1'b1, OP_INV, 8'h04, 8'h00, 8'h0F, 1'b1);
    set_lane(2'd3, 1'b1, OP_MUL, 8'h02, 8'h03, 8'h01, 1'b1);
    #1 check("t5_grant_2a", req_ready, 4'b0100);
    cycle();
    #1 check("t5_grant_3", req_ready, 4'b1000);
    cycle();
    #1 check("t5_grant_2b", req_ready, 4'b0100);
    cycle();
    #1 check("t5_pre_withdraw", req_ready, 4'b1000);
    lane_v[2] = 1'b0;
    lane_v[3] = 1'b0;
    cycle();
    lane_v[2] = 1'b1;
    lane_v[3] = 1'b1;
    #1 check("t5_ptr_held", req_ready, 4'b1000);
    cycle();
    clear_lanes();
    wait_drain();

    // 6: reset with the pipe full; first grant afterwards comes from ptr=0.
    load_set_b();
    rsp_ready = 1'b0;
    for (int k = 0; k < PIPE; k++) cycle();
    #1 check("t6_busy_full", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rsp_valid", rsp_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_req_ready", req_ready, 4'b0000);
    sb_id.delete();
    sb_data.delete();
    @(posedge clk);
    #1;
    check("t6_rsp_valid_next", rsp_valid, 1'b0);
    check("t6_busy_next", busy, 1'b0);
    check("t6_rsp_id", rsp_id, 2'd0);
    check("t6_rsp_data", rsp_data, 8'h00);
    clear_lanes();
    set_lane(2'd1, 1'b1, OP_MUL, 8'h04, 8'h04, 8'h06, 1'b1);
    set_lane(2'd3, 1'b1, OP_MUL, 8'h01, 8'h5A, 8'h5A, 1'b1);
    rsp_ready = 1'b1;
    rst = 1'b0;
    exp_ptr = 0;
    #1 check("t6_first_grant", req_ready, 4'b0010);
    cycle();
    clear_lanes();
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
